alu4_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 4-bit combinational ALU (`alu4`). It accepts operation requests from two independent clients over valid/ready handshakes and grants the ALU round-robin. It drives the ALU operand and opcode inputs from registers, captures the 4-bit result and the carry/zero/negative flags one cycle later, and returns them on a single tagged response channel. It sits between the ALU and its clients; the opcode is passed through uninterpreted.

---
 rtl/alu4_arbiter.sv | 132 +++++++++++++
 tb/tb_alu4_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared 4-bit ALU: two valid/ready
// clients, registered ALU operands, one tagged response. ALU_ARB_STATS_EN adds grant counters.
module alu4_arbiter #(
  parameter int COUNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic [3:0] alu_n1,
  output logic [3:0] alu_n2,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_neg,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [3:0] resp_result,
  output logic       resp_carry,
  output logic       resp_zero,
  output logic       resp_neg
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [COUNT_W-1:0] gnt_cnt0,
  output logic [COUNT_W-1:0] gnt_cnt1,
  input  logic               stat_clr
`endif
);

  if (COUNT_W < 1) begin : g_bad_count_w
    $error("alu4_arbiter: COUNT_W must be at least 1");
  end

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } req_t;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t     state, state_nx;
  req_t [1:0] req;
  logic [1:0] req_v;
  logic       gnt, accept, last_gnt, cur_id;

  assign req[0] = {req0_a, req0_b, req0_op};
  assign req[1] = {req1_a, req1_b, req1_op};
  assign req_v  = {req1_valid, req0_valid};

  // Client 1 wins when alone, or when both ask and client 0 won last time.
  assign gnt        = req_v[1] && (!req_v[0] || !last_gnt);
  assign accept     = (state == IDLE) && (|req_v);
  assign req0_ready = accept && !gnt;
  assign req1_ready = accept && gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_n1      <= '0;
      alu_n2      <= '0;
      alu_op      <= '0;
      cur_id      <= 1'b0;
      last_gnt    <= 1'b1;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_carry  <= 1'b0;
      resp_zero   <= 1'b0;
      resp_neg    <= 1'b0;
    end else begin
      if (accept) begin
        alu_n1   <= req[gnt].a;
        alu_n2   <= req[gnt].b;
        alu_op   <= req[gnt].op;
        cur_id   <= gnt;
        last_gnt <= gnt;
      end
      // ALU is combinational; its outputs have settled by the end of EXEC.
      if (state == EXEC) begin
        resp_valid  <= 1'b1;
        resp_id     <= cur_id;
        resp_result <= alu_out;
        resp_carry  <= alu_carry;
        resp_zero   <= alu_zero;
        resp_neg    <= alu_neg;
      end
      if (state == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating grant counters; a clear wins over a same-cycle grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (stat_clr) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_ready && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (req1_ready && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu4_arbiter.sv
// Bench for alu4_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (grant rule, in-flight queue, arithmetic reference ALU).
module tb_alu4_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [3:0] alu_n1, alu_n2, alu_out;
  logic [1:0] alu_op;
  logic       alu_carry, alu_zero, alu_neg;
  logic       resp_valid, resp_id, resp_carry, resp_zero, resp_neg;
  logic       resp_ready = 1'b0;
  logic [3:0] resp_result;
  logic       stat_clr = 1'b0;
  logic [1:0] gnt_cnt0, gnt_cnt1;

  int n_checks = 0;
  int n_fail = 0;
  bit model_last = 1'b1;

  alu4_arbiter #(.COUNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_n1(alu_n1), .alu_n2(alu_n2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_carry(resp_carry), .resp_zero(resp_zero),
    .resp_neg(resp_neg)
`ifdef ALU_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .stat_clr(stat_clr)
`endif
  );

`ifndef ALU_ARB_STATS_EN
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif

  always #5 clk = ~clk;

  // ALU stub: 00 sub (carry=borrow), 01 and, 10 add, 11 or.
  logic [4:0] stub_sum;
  always_comb begin
    stub_sum = '0;
    case (alu_op)
      2'b00:   stub_sum = {1'b0, alu_n1} - {1'b0, alu_n2};
      2'b01:   stub_sum = {1'b0, alu_n1 & alu_n2};
      2'b10:   stub_sum = {1'b0, alu_n1} + {1'b0, alu_n2};
      default: stub_sum = {1'b0, alu_n1 | alu_n2};
    endcase
  end
  assign alu_out   = stub_sum[3:0];
  assign alu_carry = stub_sum[4];
  assign alu_zero  = (stub_sum[3:0] == 4'd0);
  assign alu_neg   = stub_sum[3];

  // Reference: {carry, zero, neg, result} from integer arithmetic.
  function automatic logic [6:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    int ua, ub, s;
    bit c;
    ua = int'(a);
    ub = int'(b);
    c = 1'b0;
    case (op)
      2'd0:    begin s = ua - ub; c = (ua < ub); end
      2'd1:    s = ua & ub;
      2'd2:    begin s = ua + ub; c = (s > 15); end
      default: s = ua | ub;
    endcase
    s = s & 15;
    return {c, (s == 0), (s >= 8), 4'(s)};
  endfunction

  function automatic logic [7:0] got_resp();
    return {resp_id, resp_carry, resp_zero, resp_neg, resp_result};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b0; stat_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  // Takes one response with resp_ready high; ok=0 if none arrives in budget.
  task automatic wait_resp(output bit ok, output logic [7:0] got);
    ok = 1'b0;
    got = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = got_resp();
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    logic [7:0] got;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alu_n1, alu_n2, alu_op, resp_valid, resp_id, resp_result, resp_carry, resp_zero,
         resp_neg, req0_ready, req1_ready} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: n1=%h n2=%h op=%h rv=%b id=%b res=%h", alu_n1, alu_n2, alu_op, resp_valid, resp_id, resp_result); end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'b0111; req0_b = 4'b0111; req0_op = 2'b10;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    n_checks++;
    if ({alu_n1, alu_n2, alu_op, resp_valid} !== {4'b0111, 4'b0111, 2'b10, 1'b0})
      begin n_fail++; $display("FAIL reset_alu_inputs: n1=%b n2=%b op=%b rv=%b want 0111 0111 10 0", alu_n1, alu_n2, alu_op, resp_valid); end
    @(negedge clk);
    n_checks++;
    if ({resp_valid, resp_id, resp_carry, resp_zero, resp_neg, resp_result} !== {1'b1, 1'b0, 3'b001, 4'b1110})
      begin n_fail++; $display("FAIL reset_first_resp: rv=%b id=%b c=%b z=%b n=%b res=%b want 1 0 0 0 1 1110", resp_valid, resp_id, resp_carry, resp_zero, resp_neg, resp_result); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_done: rv=%b want 0", resp_valid); end
    model_last = 1'b0;
    ok = 1'b0; got = '0;
  endtask

  task automatic test_round_robin();
    int n, last_cyc;
    logic exp_id;
    logic [7:0] exp;
    apply_reset();
    req0_a = 4'b1000; req0_b = 4'b1000; req0_op = 2'b00;
    req1_a = 4'b0100; req1_b = 4'b0010; req1_op = 2'b11;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    n = 0; last_cyc = -1;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (req0_ready && req1_ready) begin n_fail++; $display("FAIL rr_double_ready at cycle %0d", cyc); end
      if (resp_valid) begin
        exp_id = !model_last;
        model_last = exp_id;
        exp = {exp_id, exp_id ? ref_alu(4'b0100, 4'b0010, 2'b11) : ref_alu(4'b1000, 4'b1000, 2'b00)};
        n_checks++;
        if (got_resp() !== exp || resp_id !== n[0])
          begin n_fail++; $display("FAIL rr_resp %0d: got %h want %h (id want %0d)", n, got_resp(), exp, n[0]); end
        if (n > 0) begin
          n_checks++;
          if (cyc - last_cyc != 3) begin n_fail++; $display("FAIL rr_throughput: spacing %0d want 3", cyc - last_cyc); end
        end
        n++;
        last_cyc = cyc;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (n != 6) begin n_fail++; $display("FAIL rr_count: got %0d responses want 6", n); end
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] snap, exp;
    bit ok;
    logic [7:0] got;
    // Both clients pending; model says the other side of model_last wins.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== {model_last, !model_last})
      begin n_fail++; $display("FAIL bp_grant: ready=%b%b want %b%b", req0_ready, req1_ready, model_last, !model_last); end
    exp = {!model_last, model_last ? ref_alu(4'b1000, 4'b1000, 2'b00) : ref_alu(4'b0100, 4'b0010, 2'b11)};
    model_last = !model_last;
    @(negedge clk);
    @(negedge clk);
    snap = got_resp();
    n_checks++;
    if (resp_valid !== 1'b1 || snap !== exp)
      begin n_fail++; $display("FAIL bp_first: rv=%b got %h want %h", resp_valid, snap, exp); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b1 || got_resp() !== snap || req0_ready !== 1'b0 || req1_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold %0d: rv=%b got %h want %h rdy=%b%b", i, resp_valid, got_resp(), snap, req0_ready, req1_ready); end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || {req0_ready, req1_ready} !== {model_last, !model_last})
      begin n_fail++; $display("FAIL bp_next_grant: rv=%b rdy=%b%b want 0 %b%b", resp_valid, req0_ready, req1_ready, model_last, !model_last); end
    exp = {!model_last, model_last ? ref_alu(4'b1000, 4'b1000, 2'b00) : ref_alu(4'b0100, 4'b0010, 2'b11)};
    model_last = !model_last;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(ok, got);
    n_checks++;
    if (!ok || got !== exp) begin n_fail++; $display("FAIL bp_after: ok=%b got %h want %h", ok, got, exp); end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    logic [7:0] got;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5; req0_op = 2'b10;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    n_checks++;
    if (alu_n1 !== 4'd3) begin n_fail++; $display("FAIL mid_exec_n1: got %h want 3", alu_n1); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || alu_n1 !== 4'd0 || alu_op !== 2'd0)
      begin n_fail++; $display("FAIL mid_abort: rv=%b n1=%h op=%h want 0 0 0", resp_valid, alu_n1, alu_op); end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    resp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL mid_no_resp: resp_valid rose after abort"); end
    resp_ready = 1'b0;
    req0_valid = 1'b1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reissue_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_resp(ok, got);
    model_last = 1'b0;
    n_checks++;
    if (!ok || got !== {1'b0, ref_alu(4'd3, 4'd5, 2'b10)})
      begin n_fail++; $display("FAIL mid_reissue_resp: ok=%b got %h want %h", ok, got, {1'b0, ref_alu(4'd3, 4'd5, 2'b10)}); end
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] got;
    apply_reset();
    req1_valid = 1'b1; req1_a = 4'b1100; req1_b = 4'b1000; req1_op = 2'b01;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL single_grant: rdy=%b%b want 01", req0_ready, req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_resp(ok, got);
    model_last = 1'b1;
    n_checks++;
    if (!ok || got !== {1'b1, ref_alu(4'b1100, 4'b1000, 2'b01)})
      begin n_fail++; $display("FAIL single_resp: ok=%b got %h want %h", ok, got, {1'b1, ref_alu(4'b1100, 4'b1000, 2'b01)}); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    bit busy, exp_r0, exp_r1, exp_rv, id;
    int age;
    apply_reset();
    busy = 1'b0; age = 0;
    for (int cyc = 0; cyc < 406; cyc++) begin
      @(negedge clk);
      if (cyc < 400) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req1_valid = ($urandom_range(0, 2) != 0);
        req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 2'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 2'($urandom);
        resp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      end
      #1;
      if (busy) age++;
      exp_r0 = !busy && req0_valid && (!req1_valid || model_last);
      exp_r1 = !busy && req1_valid && (!req0_valid || !model_last);
      exp_rv = busy && (age >= 2);
      n_checks++;
      if ({req0_ready, req1_ready, resp_valid} !== {exp_r0, exp_r1, exp_rv})
        begin n_fail++; $display("FAIL rand_ctrl cyc %0d: rdy=%b%b rv=%b want %b%b %b", cyc, req0_ready, req1_ready, resp_valid, exp_r0, exp_r1, exp_rv); end
      if (resp_valid && q.size() > 0) begin
        n_checks++;
        if (got_resp() !== q[0]) begin n_fail++; $display("FAIL rand_resp cyc %0d: got %h want %h", cyc, got_resp(), q[0]); end
      end
      if (exp_rv && resp_ready) begin
        void'(q.pop_front());
        busy = 1'b0;
      end else if (exp_r0 || exp_r1) begin
        id = exp_r1;
        q.push_back({id, id ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op)});
        busy = 1'b1; age = 0; model_last = id;
      end
    end
    resp_ready = 1'b0;
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL rand_drain: %0d responses outstanding", q.size()); end
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    bit ok;
    logic [7:0] got;
    apply_reset();
    req0_a = 4'd1; req0_b = 4'd2; req0_op = 2'b10;
    for (int k = 0; k < 5; k++) begin
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      wait_resp(ok, got);
    end
    n_checks++;
    if (gnt_cnt0 !== 2'd3 || gnt_cnt1 !== 2'd0)
      begin n_fail++; $display("FAIL stats_saturate: cnt0=%0d cnt1=%0d want 3 0", gnt_cnt0, gnt_cnt1); end
    req0_valid = 1'b1; stat_clr = 1'b1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL stats_clr_grant: ready=%b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0; stat_clr = 1'b0;
    n_checks++;
    if (gnt_cnt0 !== 2'd0) begin n_fail++; $display("FAIL stats_clr_priority: cnt0=%0d want 0", gnt_cnt0); end
    wait_resp(ok, got);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_single();
    test_random();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
